// File: rtl/conv_window_loader.sv
// conv_window_loader: fetches 3x3 windows, one channel at a time, from an
// input feature map RAM and presents them to a convolver with output indexing.
module conv_window_loader #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned IMG_W  = 8,
    parameter int unsigned IMG_H  = 8,
    parameter int unsigned CH     = 3,
    localparam int unsigned OW      = IMG_W - 2,
    localparam int unsigned OH      = IMG_H - 2,
    localparam int unsigned ADDR_W  = $clog2(CH * IMG_H * IMG_W),
    localparam int unsigned OADDR_W = (OW * OH > 1) ? $clog2(OW * OH) : 1,
    localparam int unsigned CH_W    = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  Index_start,
    output logic [ADDR_W-1:0]     ifmap_addr,
    output logic                  ifmap_ren,
    input  logic [DATA_W-1:0]     ifmap_rdata,
    output logic [9*DATA_W-1:0]   win_data,
    output logic [CH_W-1:0]       ch_idx,
    output logic                  Load_done,
    output logic                  whole_done,
    output logic [OADDR_W-1:0]    out_idx
);

    localparam int unsigned ROW_W = (OH > 1) ? $clog2(OH) : 1;
    localparam int unsigned COL_W = (OW > 1) ? $clog2(OW) : 1;
    localparam int unsigned K_W   = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_CAPT,
        S_DONE,
        S_WAIT,
        S_FIN
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [K_W-1:0]       r_k;
    logic [K_W-1:0]       w_k_nxt;
    logic [ROW_W-1:0]     r_row;
    logic [COL_W-1:0]     r_col;
    logic [CH_W-1:0]      r_ch;
    logic                 w_last;
    logic [31:0]          w_tap_r;
    logic [31:0]          w_tap_c;
    logic [31:0]          w_addr_full;
    logic                 r_ren;
    logic [ADDR_W-1:0]    r_addr;
    logic                 r_cap_vld;
    logic [K_W-1:0]       r_cap_k;
    logic [9*DATA_W-1:0]  r_win;
    logic [CH_W-1:0]      r_ch_idx;
    logic [OADDR_W-1:0]   r_out_idx;
    logic                 r_done;
    logic                 r_whole;

    assign ifmap_addr = r_addr;
    assign ifmap_ren  = r_ren;
    assign win_data   = r_win;
    assign ch_idx     = r_ch_idx;
    assign Load_done  = r_done;
    assign whole_done = r_whole;
    assign out_idx    = r_out_idx;

    // Current window is the final one of the map (last pixel, last channel).
    assign w_last = (r_row == ROW_W'(OH - 1)) && (r_col == COL_W'(OW - 1))
                 && (r_ch == CH_W'(CH - 1));

    // State register.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and tap counter sequencing.
    always_comb begin
        w_state_nxt = r_state;
        w_k_nxt     = r_k;
        case (r_state)
            S_IDLE: begin
                w_state_nxt = S_FETCH;
                w_k_nxt     = '0;
            end
            S_FETCH: begin
                if (r_k == K_W'(8)) begin
                    w_state_nxt = S_CAPT;
                    w_k_nxt     = '0;
                end else begin
                    w_k_nxt = r_k + K_W'(1);
                end
            end
            S_CAPT: w_state_nxt = S_DONE;
            S_DONE: w_state_nxt = w_last ? S_FIN : S_WAIT;
            S_WAIT: begin
                if (Index_start) begin
                    w_state_nxt = S_FETCH;
                    w_k_nxt     = '0;
                end
            end
            S_FIN:   w_state_nxt = S_FIN;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // RAM address of the tap issued next cycle.
    always_comb begin
        w_tap_r     = 32'(w_k_nxt) / 32'd3;
        w_tap_c     = 32'(w_k_nxt) % 32'd3;
        w_addr_full = 32'(r_ch) * IMG_H * IMG_W
                    + (32'(r_row) + w_tap_r) * IMG_W
                    + 32'(r_col) + w_tap_c;
    end

    // Read port, handshake flags, window position counters.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_k       <= '0;
            r_row     <= '0;
            r_col     <= '0;
            r_ch      <= '0;
            r_ren     <= 1'b0;
            r_addr    <= '0;
            r_cap_vld <= 1'b0;
            r_cap_k   <= '0;
            r_done    <= 1'b0;
            r_whole   <= 1'b0;
            r_ch_idx  <= '0;
            r_out_idx <= '0;
        end else begin
            r_k       <= w_k_nxt;
            r_ren     <= (w_state_nxt == S_FETCH);
            r_addr    <= (w_state_nxt == S_FETCH) ? ADDR_W'(w_addr_full) : '0;
            r_cap_vld <= r_ren;
            r_cap_k   <= r_k;
            r_done    <= (w_state_nxt == S_DONE);
            if (w_state_nxt == S_DONE) begin
                r_ch_idx  <= r_ch;
                r_out_idx <= OADDR_W'(32'(r_row) * OW + 32'(r_col));
                if (w_last) begin
                    r_whole <= 1'b1;
                end
            end
            if ((r_state == S_DONE) && !w_last) begin
                if (r_ch == CH_W'(CH - 1)) begin
                    r_ch <= '0;
                    if (r_col == COL_W'(OW - 1)) begin
                        r_col <= '0;
                        r_row <= r_row + ROW_W'(1);
                    end else begin
                        r_col <= r_col + COL_W'(1);
                    end
                end else begin
                    r_ch <= r_ch + CH_W'(1);
                end
            end
        end
    end

    // Capture returning read data into its tap slot, one cycle after the address.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_win <= '0;
        end else if (r_cap_vld) begin
            for (int k = 0; k < 9; k++) begin
                if (r_cap_k == K_W'(k)) begin
                    r_win[k*DATA_W +: DATA_W] <= ifmap_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_conv_window_loader.sv
// Bench for conv_window_loader on a 4x4x2 map whose RAM returns its own address.
module tb_conv_window_loader;

    localparam int unsigned DW = 8;

    typedef struct {
        logic [71:0] win;
        logic        ch;
        logic [1:0]  oi;
        logic        last;
    } exp_t;

    logic        CLK = 1'b0;
    logic        RST;
    logic        Index_start;
    logic [4:0]  ifmap_addr;
    logic        ifmap_ren;
    logic [7:0]  ifmap_rdata;
    logic [71:0] win_data;
    logic        ch_idx;
    logic        Load_done;
    logic        whole_done;
    logic [1:0]  out_idx;

    int   n_total = 0;
    int   n_bad   = 0;
    int   cyc     = 0;
    int   done_cnt = 0;
    int   done_cyc = 0;
    int   first_addr_cyc = 0;
    int   t_start = 0;
    logic mon_en = 1'b0;
    logic prev_done = 1'b0;
    logic prev_ren  = 1'b0;
    logic [4:0] mon_a;
    exp_t mon_e;
    logic [4:0] q_addr[$];
    exp_t       q_win[$];

    conv_window_loader #(
        .DATA_W(DW), .IMG_W(4), .IMG_H(4), .CH(2)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .Index_start(Index_start),
        .ifmap_addr (ifmap_addr),
        .ifmap_ren  (ifmap_ren),
        .ifmap_rdata(ifmap_rdata),
        .win_data   (win_data),
        .ch_idx     (ch_idx),
        .Load_done  (Load_done),
        .whole_done (whole_done),
        .out_idx    (out_idx)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // Feature map RAM with RAM[a] = a and one cycle read latency.
    always @(posedge CLK) if (ifmap_ren) ifmap_rdata <= 8'(ifmap_addr);

    task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Expected addresses and finished window for load number n of the map.
    task automatic push_window(input int n);
        exp_t e;
        int c, pix, r, co, a;
        c = n % 2; pix = n / 2; r = pix / 2; co = pix % 2;
        e.win = '0;
        for (int k = 0; k < 9; k++) begin
            a = c * 16 + (r + k / 3) * 4 + co + k % 3;
            q_addr.push_back(5'(a));
            e.win[k*8 +: 8] = 8'(a);
        end
        e.ch   = 1'(c);
        e.oi   = 2'(pix);
        e.last = (n == 7);
        q_win.push_back(e);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_ren"},   72'(ifmap_ren),  72'(0));
        chk({tag, "_addr"},  72'(ifmap_addr), 72'(0));
        chk({tag, "_done"},  72'(Load_done),  72'(0));
        chk({tag, "_whole"}, 72'(whole_done), 72'(0));
        chk({tag, "_win"},   win_data,        72'(0));
        chk({tag, "_ch"},    72'(ch_idx),     72'(0));
        chk({tag, "_oidx"},  72'(out_idx),    72'(0));
    endtask

    task automatic pulse_start();
        @(negedge CLK) Index_start = 1'b1;
        @(posedge CLK);
        #1 t_start = cyc;
        @(negedge CLK) Index_start = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(posedge CLK);
            if (done_cnt >= target) break;
        end
        chk("load_count", 72'(done_cnt), 72'(target));
    endtask

    // Scoreboard monitor: pops expected addresses and windows as the DUT emits them.
    always @(negedge CLK) begin
        if (!mon_en) begin
            prev_done = 1'b0;
            prev_ren  = 1'b0;
        end else begin
            if (ifmap_ren) begin
                if (!prev_ren) first_addr_cyc = cyc;
                if (q_addr.size() == 0) begin
                    chk("ren_outside_fetch", 72'(ifmap_ren), 72'(0));
                end else begin
                    mon_a = q_addr.pop_front();
                    chk("addr", 72'(ifmap_addr), 72'(mon_a));
                end
            end else begin
                chk("addr_idle", 72'(ifmap_addr), 72'(0));
            end
            if (Load_done) begin
                chk("done_twice", 72'(prev_done), 72'(0));
                done_cyc = cyc;
                done_cnt++;
                if (q_win.size() == 0) begin
                    chk("done_extra", 72'(Load_done), 72'(0));
                end else begin
                    mon_e = q_win.pop_front();
                    chk("win_data", win_data, mon_e.win);
                    chk("ch_idx", 72'(ch_idx), 72'(mon_e.ch));
                    chk("out_idx", 72'(out_idx), 72'(mon_e.oi));
                    chk("whole_at_done", 72'(whole_done), 72'(mon_e.last));
                end
            end
            prev_done = Load_done;
            prev_ren  = ifmap_ren;
        end
    end

    initial begin
        logic found;
        RST = 1'b0;
        Index_start = 1'b0;
        repeat (3) @(posedge CLK);
        #1 check_reset("rst0");

        // First window loads straight out of reset.
        push_window(0);
        @(negedge CLK) begin RST = 1'b1; mon_en = 1'b1; end
        wait_done(1, 40);

        // Second window: channel 1 of pixel 0, with latency checks.
        push_window(1);
        pulse_start();
        wait_done(2, 40);
        chk("lat_first_addr", 72'(first_addr_cyc - t_start), 72'(0));
        chk("lat_done", 72'(done_cyc - t_start), 72'(10));

        // Third window with a stray start pulse during the fetch.
        push_window(2);
        pulse_start();
        repeat (3) @(posedge CLK);
        pulse_start();
        wait_done(3, 40);
        repeat (15) @(posedge CLK);
        chk("fetch_pulse_ignored", 72'(done_cnt), 72'(3));

        for (int n = 3; n < 8; n++) begin
            push_window(n);
            pulse_start();
            wait_done(n + 1, 40);
        end
        repeat (3) @(posedge CLK);
        #1 chk("whole_held", 72'(whole_done), 72'(1));
        pulse_start();
        repeat (15) @(posedge CLK);
        chk("fin_start_ignored", 72'(done_cnt), 72'(8));
        #1 chk("whole_held2", 72'(whole_done), 72'(1));

        // Reset out of FIN restarts at window 0.
        @(negedge CLK) begin RST = 1'b0; mon_en = 1'b0; end
        @(posedge CLK);
        #1 check_reset("rst_fin");
        q_addr.delete();
        q_win.delete();
        push_window(0);
        @(negedge CLK) begin RST = 1'b1; mon_en = 1'b1; end
        wait_done(9, 40);

        // Reset at tap 4 of the second window.
        push_window(1);
        pulse_start();
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge CLK);
            #1;
            if (ifmap_ren && ifmap_addr == 5'd21) begin
                found = 1'b1;
                break;
            end
        end
        chk("tap4_seen", 72'(found), 72'(1));
        RST = 1'b0;
        @(negedge CLK);
        #1 mon_en = 1'b0;
        @(posedge CLK);
        #1 check_reset("rst_mid");
        q_addr.delete();
        q_win.delete();
        push_window(0);
        @(negedge CLK) begin RST = 1'b1; mon_en = 1'b1; end
        wait_done(10, 40);
        chk("addr_q_empty", 72'(q_addr.size()), 72'(0));

        repeat (2) @(posedge CLK);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
